bf_data_sequencer: RTL

- Data-side partner of the FFT address generator in AGU_MODE_BF_RAM.
- The AGU issues read and write addresses in an 8-slot butterfly window. This block captures the RAM read data returned in the same slot order (br, wr, bi, wi, ar, ai) and presents a coherent operand set to the butterfly unit.
- It latches the butterfly results and serialises them (r1r, r1i, r2r, r2i) onto the RAM write-data bus, with a write strobe aligned to the AGU write-address slots.
- It tracks butterflies per stage and flags stage completion.

---
 rtl/bf_data_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bf_data_sequencer.sv
// Data-side partner of the butterfly-mode address generator: captures RAM read data into an
// operand set, serialises butterfly results onto the write bus, and counts butterflies per stage.
module bf_data_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int N_POINTS   = 128,
   parameter int LOG_N      = 7,
   parameter int MODE_WIDTH = 2,
   parameter int MODE_BF    = 2
) (
   input  logic                  controlPulse,
   input  logic                  reset,
   input  logic                  c_seq_start,
   input  logic [MODE_WIDTH-1:0] c_mode,
   input  logic [DATA_WIDTH-1:0] readData,
   output logic [DATA_WIDTH-1:0] ar,
   output logic [DATA_WIDTH-1:0] ai,
   output logic [DATA_WIDTH-1:0] br,
   output logic [DATA_WIDTH-1:0] bi,
   output logic [DATA_WIDTH-1:0] wr,
   output logic [DATA_WIDTH-1:0] wi,
   output logic                  bf_start,
   input  logic [DATA_WIDTH-1:0] r1r,
   input  logic [DATA_WIDTH-1:0] r1i,
   input  logic [DATA_WIDTH-1:0] r2r,
   input  logic [DATA_WIDTH-1:0] r2i,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  x_we_data,
   output logic [LOG_N-1:0]      xBfCount,
   output logic                  stage_done
);

   logic [2:0]            slot;
   logic                  run;
   logic                  res_valid;
   logic                  bf_seen;
   logic [DATA_WIDTH-1:0] br_s, wr_s, bi_s, wi_s, ar_s, ai_s;
   logic [DATA_WIDTH-1:0] r1r_q, r1i_q, r2r_q, r2i_q;

   logic mode_bf;
   logic active;
   logic start;
   logic last_bf;

   assign mode_bf = (c_mode == MODE_WIDTH'(MODE_BF));
   // Once a result is latched the slot keeps counting until its four writes are out.
   assign active  = run && (mode_bf || res_valid);
   assign start   = !run && c_seq_start && mode_bf;
   assign last_bf = (xBfCount == LOG_N'(N_POINTS / 2 - 1));

   always_ff @(posedge controlPulse or posedge reset) begin
      if (reset) begin
         slot       <= 3'd7;
         run        <= 1'b0;
         res_valid  <= 1'b0;
         bf_seen    <= 1'b0;
         br_s       <= '0;
         wr_s       <= '0;
         bi_s       <= '0;
         wi_s       <= '0;
         ar_s       <= '0;
         ai_s       <= '0;
         ar         <= '0;
         ai         <= '0;
         br         <= '0;
         bi         <= '0;
         wr         <= '0;
         wi         <= '0;
         r1r_q      <= '0;
         r1i_q      <= '0;
         r2r_q      <= '0;
         r2i_q      <= '0;
         writeData  <= '0;
         x_we_data  <= 1'b0;
         xBfCount   <= '0;
         bf_start   <= 1'b0;
         stage_done <= 1'b0;
      end else begin
         bf_start   <= 1'b0;
         stage_done <= 1'b0;
         if (start) begin
            run     <= 1'b1;
            slot    <= 3'd0;
            bf_seen <= 1'b0;
         end else if (run && !active) begin
            run     <= 1'b0;
            slot    <= 3'd7;
            bf_seen <= 1'b0;
         end else if (active) begin
            slot <= slot + 3'd1;
            if (mode_bf) begin
               case (slot)
                  3'd1: br_s <= readData;
                  3'd2: wr_s <= readData;
                  3'd3: bi_s <= readData;
                  3'd4: wi_s <= readData;
                  3'd5: ar_s <= readData;
                  3'd6: ai_s <= readData;
                  3'd7: begin
                     br       <= br_s;
                     wr       <= wr_s;
                     bi       <= bi_s;
                     wi       <= wi_s;
                     ar       <= ar_s;
                     ai       <= ai_s;
                     bf_start <= 1'b1;
                     bf_seen  <= 1'b1;
                  end
                  default: ;
               endcase
               // The butterfly has had slots 0..5 to settle on the operands presented at slot 0.
               if (slot == 3'd5 && bf_seen) begin
                  r1r_q     <= r1r;
                  r1i_q     <= r1i;
                  r2r_q     <= r2r;
                  r2i_q     <= r2i;
                  res_valid <= 1'b1;
               end
            end
            if (res_valid) begin
               case (slot)
                  3'd6: begin
                     writeData <= r1r_q;
                     x_we_data <= 1'b1;
                  end
                  3'd7: writeData <= r1i_q;
                  3'd0: writeData <= r2r_q;
                  3'd1: writeData <= r2i_q;
                  3'd2: begin
                     x_we_data <= 1'b0;
                     res_valid <= 1'b0;
                     if (last_bf) begin
                        xBfCount   <= '0;
                        stage_done <= 1'b1;
                     end else begin
                        xBfCount <= xBfCount + LOG_N'(1);
                     end
                     if (!mode_bf) begin
                        run     <= 1'b0;
                        slot    <= 3'd7;
                        bf_seen <= 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
